// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: initiator FSM states, response codes and default protection.
package axi_lite_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWrResp,
    StRdAddr,
    StRdData,
    StDone
  } axi_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one user command in, one AXI transaction out,
// one response pulse back, with a bounded response timeout.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  axi_clk,
  input  logic                  axi_rst,
  // user command / response
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  // AXI4-Lite master
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int unsigned StrbW   = DATA_W / 8;
  localparam int unsigned CntW    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          TmoEn   = (TIMEOUT_CYCLES != 0);
  // Abort on the edge that would bring the count to TIMEOUT_CYCLES.
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);

  axi_state_e           state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [StrbW-1:0]     wstrb_q, wstrb_d;
  logic                 awvalid_q, awvalid_d;
  logic                 wvalid_q, wvalid_d;
  logic                 arvalid_q, arvalid_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic [1:0]           rsp_resp_q, rsp_resp_d;
  logic                 rsp_timeout_q, rsp_timeout_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic active;
  logic tmo;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    arvalid_d     = arvalid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    active = (state_q == StWr) || (state_q == StWrResp) ||
             (state_q == StRdAddr) || (state_q == StRdData);
    tmo    = TmoEn && active && (cnt_q == TmoLast);

    if (active && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          cnt_d  = '0;
          if (cmd_write) begin
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWr;
          end else begin
            arvalid_d = 1'b1;
            state_d   = StRdAddr;
          end
        end
      end
      StWr: begin
        // AW and W retire independently; move on once neither is still pending.
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)    state_d   = StWrResp;
      end
      StWrResp: begin
        if (m_axi_bvalid) begin
          rsp_resp_d    = m_axi_bresp;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
          state_d       = StDone;
        end
      end
      StRdAddr: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = StRdData;
        end
      end
      StRdData: begin
        if (m_axi_rvalid) begin
          rsp_resp_d    = m_axi_rresp;
          rsp_rdata_d   = m_axi_rdata;
          rsp_timeout_d = 1'b0;
          state_d       = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A B/R handshake in the expiry cycle takes priority over the abort.
    if (tmo && !((state_q == StWrResp) && m_axi_bvalid) &&
        !((state_q == StRdData) && m_axi_rvalid)) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      arvalid_d     = 1'b0;
      rsp_resp_d    = RESP_SLVERR;
      rsp_rdata_d   = '0;
      rsp_timeout_d = 1'b1;
      state_d       = StDone;
    end
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      arvalid_q     <= arvalid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready     = (state_q == StIdle);
  assign rsp_valid     = (state_q == StDone);
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = PROT_DEFAULT;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state_q == StWrResp);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = PROT_DEFAULT;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = (state_q == StRdData);

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master against a small behavioural AXI4-Lite register slave.
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_lite_master #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .axi_clk      (clk),
    .axi_rst      (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .rsp_timeout  (rsp_timeout),
    .m_axi_awaddr (awaddr),
    .m_axi_awprot (awprot),
    .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata  (wdata),
    .m_axi_wstrb  (wstrb),
    .m_axi_wvalid (wvalid),
    .m_axi_wready (wready),
    .m_axi_bresp  (bresp),
    .m_axi_bvalid (bvalid),
    .m_axi_bready (bready),
    .m_axi_araddr (araddr),
    .m_axi_arprot (arprot),
    .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rdata  (rdata),
    .m_axi_rresp  (rresp),
    .m_axi_rvalid (rvalid),
    .m_axi_rready (rready)
  );

  // ---------------- behavioural slave ----------------
  logic [31:0] mem [16];
  int          aw_wait = 0, w_wait = 0;
  bit          ar_block = 0, b_block = 0, mem_init = 1;
  int          aw_cnt, w_cnt;
  logic        aw_got, w_got, bvalid_r, rvalid_r;
  logic [3:0]  aw_idx_l;
  logic [31:0] w_data_l;
  logic [3:0]  w_strb_l;
  logic [31:0] rdata_r;
  logic [1:0]  rresp_r;
  logic        aw_hs, w_hs, wr_fire;
  logic [3:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  assign awready = awvalid && (aw_cnt >= aw_wait);
  assign wready  = wvalid && (w_cnt >= w_wait);
  assign arready = arvalid && !ar_block;
  assign bvalid  = bvalid_r && !b_block;
  assign bresp   = 2'b00;
  assign rvalid  = rvalid_r;
  assign rdata   = rdata_r;
  assign rresp   = rresp_r;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign wr_fire = (aw_got || aw_hs) && (w_got || w_hs) && !bvalid_r;
  assign wr_idx  = aw_hs ? awaddr[3:0] : aw_idx_l;
  assign wr_data = w_hs ? wdata : w_data_l;
  assign wr_strb = w_hs ? wstrb : w_strb_l;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt   <= 0;
      w_cnt    <= 0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      bvalid_r <= 1'b0;
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
      rresp_r  <= '0;
      aw_idx_l <= '0;
      w_data_l <= '0;
      w_strb_l <= '0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      if (wr_fire) begin
        bvalid_r <= 1'b1;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_got   <= 1'b1;
          aw_idx_l <= awaddr[3:0];
        end
        if (w_hs) begin
          w_got    <= 1'b1;
          w_data_l <= wdata;
          w_strb_l <= wstrb;
        end
        if (bvalid && bready) bvalid_r <= 1'b0;
      end
      if (arvalid && arready) begin
        rvalid_r <= 1'b1;
        rdata_r  <= mem[araddr[3:0]];
        rresp_r  <= (araddr == 32'h100) ? 2'b11 : 2'b00;
      end else if (rvalid_r && rready) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  // Memory survives reset so data written before a mid-transaction reset stays readable.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (!rst && wr_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a negedge while idle; returns at the negedge of the first cycle after accept.
  task automatic send_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int start, output int lat, output bit seen);
    lat  = start;
    seen = 1'b0;
    while (!seen && lat < 64) begin
      if (rsp_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [7:0]   ctl;
    logic [140:0] dat;
    ctl = {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout};
    dat = {awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp, awprot, arprot};
    checks++;
    if (ctl !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 10000000", ctl);
    end
    checks++;
    if (dat !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", dat);
    end
  endtask

  task automatic test_write;
    int lat;
    bit seen;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_idle_ready: got %b want 1", cmd_ready);
    end
    send_cmd(1'b1, 32'd3, 32'hDEADBEEF, 4'hF);
    checks++;
    if ({awvalid, wvalid, bready, cmd_ready, awaddr, wdata, wstrb} !==
        {4'b1100, 32'd3, 32'hDEADBEEF, 4'hF}) begin
      errors++;
      $display("FAIL wr_issue: got aw%b w%b b%b rdy%b addr %h data %h strb %h",
               awvalid, wvalid, bready, cmd_ready, awaddr, wdata, wstrb);
    end
    @(negedge clk);
    checks++;
    if ({awvalid, wvalid, bready} !== 3'b001) begin
      errors++;
      $display("FAIL wr_bphase: got %b want 001", {awvalid, wvalid, bready});
    end
    wait_rsp(2, lat, seen);
    checks++;
    if (!seen || lat != 3) begin
      errors++;
      $display("FAIL wr_latency: got %0d (seen %b) want 3", lat, seen);
    end
    checks++;
    if ({rsp_resp, rsp_timeout, rsp_rdata} !== 35'd0) begin
      errors++;
      $display("FAIL wr_rsp: got resp %b to %b rdata %h want 0/0/0",
               rsp_resp, rsp_timeout, rsp_rdata);
    end
    checks++;
    if (mem[3] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_mem: got %h want deadbeef", mem[3]);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL wr_after: got valid %b ready %b want 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_read(input logic [31:0] a, input logic [31:0] exp_d,
                           input logic [1:0] exp_r);
    int lat;
    bit seen;
    send_cmd(1'b0, a, 32'h0, 4'h0);
    checks++;
    if ({arvalid, rready, araddr} !== {2'b10, a}) begin
      errors++;
      $display("FAIL rd_issue: got ar%b r%b addr %h want 1 0 %h", arvalid, rready, araddr, a);
    end
    wait_rsp(1, lat, seen);
    checks++;
    if (!seen || lat != 3) begin
      errors++;
      $display("FAIL rd_latency addr %h: got %0d (seen %b) want 3", a, lat, seen);
    end
    checks++;
    if ({rsp_rdata, rsp_resp, rsp_timeout} !== {exp_d, exp_r, 1'b0}) begin
      errors++;
      $display("FAIL rd_rsp addr %h: got %h/%b/%b want %h/%b/0",
               a, rsp_rdata, rsp_resp, rsp_timeout, exp_d, exp_r);
    end
    @(negedge clk);
  endtask

  task automatic test_split_handshake;
    int cyc = 1, w_low = 0, aw_low = 0, b_hi = 0;
    bit bad = 1'b0;
    aw_wait = 5;
    send_cmd(1'b1, 32'd5, 32'h12345678, 4'h3);
    while (!rsp_valid && cyc < 40) begin
      if (!wvalid && w_low == 0) w_low = cyc;
      if (!awvalid && aw_low == 0) aw_low = cyc;
      if (wvalid && w_low != 0) bad = 1'b1;
      if (awvalid && aw_low != 0) bad = 1'b1;
      if (bready && b_hi == 0) b_hi = cyc;
      if (bready && (awvalid || wvalid)) bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    aw_wait = 0;
    checks++;
    if (w_low != 2 || aw_low != 7 || b_hi != 7 || bad) begin
      errors++;
      $display("FAIL split_order: got wlow %0d awlow %0d bhi %0d bad %b want 2 7 7 0",
               w_low, aw_low, b_hi, bad);
    end
    checks++;
    if (cyc != 8 || rsp_resp !== 2'b00 || rsp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL split_rsp: got lat %0d resp %b to %b want 8 00 0",
               cyc, rsp_resp, rsp_timeout);
    end
    checks++;
    if (mem[5] !== 32'h00005678) begin
      errors++;
      $display("FAIL split_strb: got %h want 00005678", mem[5]);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int cyc = 1, ar_hi = 0;
    ar_block = 1'b1;
    send_cmd(1'b0, 32'd7, 32'h0, 4'h0);
    while (!rsp_valid && cyc < 40) begin
      if (arvalid) ar_hi++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (ar_hi != 16 || cyc != 17 || arvalid !== 1'b0) begin
      errors++;
      $display("FAIL tmo_timing: got arhigh %0d lat %0d arvalid %b want 16 17 0",
               ar_hi, cyc, arvalid);
    end
    checks++;
    if ({rsp_resp, rsp_timeout, rsp_rdata} !== {2'b10, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL tmo_rsp: got resp %b to %b rdata %h want 10 1 0",
               rsp_resp, rsp_timeout, rsp_rdata);
    end
    ar_block = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rready} !== 3'b100) begin
      errors++;
      $display("FAIL tmo_after: got %b want 100", {cmd_ready, rsp_valid, rready});
    end
  endtask

  task automatic test_reset_mid;
    bit pulse = 1'b0;
    b_block = 1'b1;
    send_cmd(1'b1, 32'd9, 32'hA5A5A5A5, 4'hF);
    @(negedge clk);
    checks++;
    if (bready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_state: got bready %b want 1", bready);
    end
    rst = 1'b1;
    #1;
    test_reset();
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) pulse = 1'b1;
    end
    rst = 1'b0;
    b_block = 1'b0;
    @(negedge clk);
    if (rsp_valid) pulse = 1'b1;
    checks++;
    if (pulse) begin
      errors++;
      $display("FAIL rst_mid_pulse: got rsp_valid 1 want 0");
    end
    test_read(32'd3, 32'hDEADBEEF, 2'b00);
  endtask

  task automatic test_back_to_back;
    // Each read returns to idle at the negedge after its pulse; the next accept follows at once.
    test_read(32'd3, 32'hDEADBEEF, 2'b00);
    test_read(32'd5, 32'h00005678, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    repeat (3) @(negedge clk);
    test_reset();
    mem_init = 1'b0;
    rst = 1'b0;
    test_write();
    test_read(32'd3, 32'hDEADBEEF, 2'b00);
    test_split_handshake();
    test_timeout();
    test_read(32'h100, 32'h0, 2'b11);
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
